// File: rtl/dmem_seq_pkg.sv
// Shared constants and helpers for the data-memory access sequencer:
// load/store funct3 codes, FSM state encoding, and request classification.
package dmem_seq_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP,
    WR_A,
    WR_B,
    RESP
  } seq_state_e;

  // Stores only know B/H/W; loads additionally know BU/HU.
  function automatic logic f3_unsupported(input logic we, input logic [2:0] f3);
    if (we) return f3 > F3_W;
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  // True when the access touches bytes of two consecutive words.
  function automatic logic crosses_word(input logic [2:0] f3, input logic [1:0] off);
    return ((f3 == F3_H || f3 == F3_HU) && off == 2'd3) || (f3 == F3_W && off != 2'd0);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: load extract/extend from the {bufB,bufA} pair and
// store-byte merging into both word images.
module dmem_lane_align
  import dmem_seq_pkg::*;
(
  input  logic [31:0] buf_a,
  input  logic [31:0] buf_b,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_a,
  output logic [31:0] store_b
);

  logic [63:0] pair;
  logic [31:0] ext;
  logic [63:0] data64;
  logic [63:0] merged;
  logic [3:0]  mask4;
  logic [7:0]  mask8;

  assign pair = {buf_b, buf_a};
  assign ext  = 32'(pair >> {off, 3'b000});

  always_comb begin
    load_data = '0;
    unique case (funct3)
      F3_B:    load_data = {{24{ext[7]}}, ext[7:0]};
      F3_H:    load_data = {{16{ext[15]}}, ext[15:0]};
      F3_W:    load_data = ext;
      F3_BU:   load_data = {24'h000000, ext[7:0]};
      F3_HU:   load_data = {16'h0000, ext[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    mask4 = 4'b1111;
    unique case (funct3[1:0])
      2'b00:   mask4 = 4'b0001;
      2'b01:   mask4 = 4'b0011;
      default: mask4 = 4'b1111;
    endcase
  end

  // Lanes above byte 3 spill into word B for crossing stores.
  assign mask8  = {4'b0000, mask4} << off;
  assign data64 = {32'h0000_0000, wdata} << {off, 3'b000};

  always_comb begin
    merged = '0;
    for (int i = 0; i < 8; i++) begin
      merged[8*i +: 8] = mask8[i] ? data64[8*i +: 8] : pair[8*i +: 8];
    end
  end

  assign store_a = merged[31:0];
  assign store_b = merged[63:32];

endmodule

// File: rtl/dmem_access_seq.sv
// Load/store sequencer onto a word-only data memory: sub-word RMW and word-crossing splits.
// Define MISALIGN_TRAP_EN to return an error for word-crossing requests instead of splitting.
module dmem_access_seq
  import dmem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  seq_state_e        state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] word_a_q;
  logic              split_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   buf_a_q;
  logic [XLEN-1:0]   buf_b_q;

  logic [1:0]        req_off;
  logic [ADDR_W-1:0] req_word;
  logic              req_split;
  logic              req_err;
  logic [ADDR_W-1:0] word_b;
  logic [XLEN-1:0]   buf_a_cur;
  logic [XLEN-1:0]   buf_b_cur;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   store_a;
  logic [XLEN-1:0]   store_b;
  logic              unused_addr;

  assign req_off     = req_addr[1:0];
  assign req_word    = req_addr[ADDR_W+1:2];
  assign req_split   = crosses_word(req_funct3, req_off);
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign word_b      = word_a_q + ADDR_W'(1);
  assign req_ready   = (state_q == IDLE);

`ifdef MISALIGN_TRAP_EN
  assign req_err = f3_unsupported(req_we, req_funct3) || req_split;
`else
  assign req_err = f3_unsupported(req_we, req_funct3);
`endif

  // Outputs are registered, so the lane logic sees the word arriving this cycle.
  assign buf_a_cur = (state_q == RD_B) ? mem_rdata : buf_a_q;
  assign buf_b_cur = (state_q == CAP)  ? mem_rdata : buf_b_q;

  dmem_lane_align u_lane_align (
    .buf_a     (buf_a_cur),
    .buf_b     (buf_b_cur),
    .wdata     (wdata_q),
    .off       (off_q),
    .funct3    (f3_q),
    .load_data (load_data),
    .store_a   (store_a),
    .store_b   (store_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      word_a_q  <= '0;
      split_q   <= 1'b0;
      wdata_q   <= '0;
      buf_a_q   <= '0;
      buf_b_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            f3_q     <= req_funct3;
            off_q    <= req_off;
            word_a_q <= req_word;
            split_q  <= req_split;
            wdata_q  <= req_wdata;
            if (req_err) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && req_funct3 == F3_W && req_off == 2'd0) begin
              state_q   <= WR_A;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= req_word;
              mem_wdata <= req_wdata;
            end else begin
              state_q  <= RD_A;
              mem_en   <= 1'b1;
              mem_addr <= req_word;
            end
          end
        end
        RD_A: begin
          state_q <= RD_B;
          if (split_q) begin
            mem_en   <= 1'b1;
            mem_addr <= word_b;
          end
        end
        RD_B, CAP: begin
          if (state_q == RD_B) buf_a_q <= mem_rdata;
          else                 buf_b_q <= mem_rdata;
          if (state_q == RD_B && split_q) begin
            state_q <= CAP;
          end else if (we_q) begin
            state_q   <= WR_A;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= word_a_q;
            mem_wdata <= store_a;
          end else begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end
        end
        WR_A: begin
          if (split_q) begin
            state_q   <= WR_B;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= word_b;
            mem_wdata <= store_b;
          end else begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        WR_B: begin
          state_q   <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        RESP: begin
          state_q   <= IDLE;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_access_seq.md
Name: dmem_access_seq

Overview:
- Sequencer between the core load/store unit and a word-wide, word-addressed data memory that only performs full-word reads and writes.
- Turns each byte/half/word load or store, at any byte offset, into aligned word reads, read-modify-write merges and word writes.
- Splits accesses that cross a word boundary into two word transactions.
- One request in flight; valid/ready request side, single-cycle response pulse.

Parameters:
- ADDR_W, 18: memory word-index width (2^18 words = 1 MiB).
- XLEN, 32: data width; only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address; bits [ADDR_W+1:0] used
- req_wdata  in  32  store data, little-endian, LSB-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  unsupported funct3 or trapped misalignment, valid with rsp_valid
- mem_en  out  1  memory access this cycle
- mem_we  out  1  1 = word write
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid the cycle after a read with mem_en=1 and mem_we=0

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_en=0; mem_we=0; mem_addr=0; mem_wdata=0; internal buffers cleared.
- Reset mid-operation abandons the request. A split store may leave word A written and word B not written; this is accepted.
- Request acceptance: a request is accepted when req_valid && req_ready in IDLE; all request fields are registered on acceptance.
- Byte offset and split: off = addr[1:0]; word A = addr[ADDR_W+1:2]; word B = A+1, wrapping from 2^ADDR_W-1 to 0.
  - A request is split when LH/LHU/SH have off=3, or LW/SW have off≠0.
- States, one per cycle:
  - IDLE: on accept, go to RESP if error; WR_A if aligned SW; otherwise RD_A.
  - RD_A: mem_en=1, mem_we=0, mem_addr=A.
  - RD_B: capture mem_rdata into bufA. If split: read B and go to CAP. Else: load → RESP, store → WR_A.
  - CAP: capture bufB. Load → RESP, store → WR_A.
  - WR_A: mem_en=1, mem_we=1, write bufA with store bytes merged at their lanes. Go to WR_B if split, else RESP.
  - WR_B: write bufB with the remaining upper store bytes at lanes 0 upward, then RESP.
  - RESP: rsp_valid=1; go to IDLE.
- Latency (acceptance = cycle 0, rsp_valid in the given cycle):
  - aligned load: 3; split load: 4
  - aligned SW: 2
  - SB/SH non-split: 4
  - split SH/SW: 6
- Load extract: bytes taken from {bufB,bufA} shifted right by off*8.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes 32 bits.
- Error: load funct3 011/110/111, or store funct3 ≥ 011.
  - No memory access; RESP with rsp_err=1 and rsp_rdata=0.
- mem_en=0 in IDLE and RESP, and in RD_B when not split. mem_we=1 only in WR_A and WR_B.
- req_valid deasserted while busy is ignored. The next request can be accepted in the cycle after RESP.

Optional Feature:
- MISALIGN_TRAP_EN defined: split requests are not executed. They go IDLE → RESP with rsp_err=1, rsp_rdata=0 and no memory traffic; CAP and WR_B become unreachable.
- MISALIGN_TRAP_EN undefined: split requests are executed as above.

Decomposition:
- Package dmem_seq_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state encoding constants: IDLE, RD_A, RD_B, CAP, WR_A, WR_B, RESP
- One combinational sub-module, dmem_lane_align, does the byte-lane work:
  - builds the load extract/extend from {bufB,bufA}, off and funct3
  - builds the merged store words for A and B from bufA, bufB, wdata, off and funct3
- The FSM, registers and handshake stay in dmem_access_seq.

Test Plan:
- Aligned round trip: SW addr 0x100, data 0xDEADBEEF, then LW 0x100.
  - SW: write A=0x40 at cycle 1, rsp at cycle 2.
  - LW: rsp_rdata 0xDEADBEEF at cycle 3.
- Sub-word extend: mem word 0x40 = 0x80FF7F01.
  - LB 0x103 → 0xFFFFFF80; LBU 0x103 → 0x00000080; LH 0x102 → 0xFFFF80FF; LHU 0x100 → 0x00007F01.
- Split store and load: SW 0x101 with 0x11223344 over words 0x40=0xAAAAAAAA and 0x41=0xBBBBBBBB.
  - Word 0x40 becomes 0x223344AA; word 0x41 becomes 0xBBBBBB11.
  - rsp at cycle 6; a following LW 0x101 returns 0x11223344 at cycle 4.
- Wrap and error:
  - LH at byte address 4*(2^ADDR_W)-1 reads word index 2^ADDR_W-1, then word 0.
  - Load funct3=011 → rsp_err=1 at cycle 1 with no mem_en.
- Reset: rst_n low during WR_A of a split SW.
  - Outputs go to reset values immediately and word B is unchanged.
  - A new aligned LW completes normally after reset.
- Build with MISALIGN_TRAP_EN: LW 0x102 → rsp_err=1 at cycle 1 with no memory traffic; aligned traffic is unaffected.
